// File: rtl/uart_rx_oversampled.sv
// rtl/uart_rx_oversampled.sv - Oversampling UART receiver with ready/valid output and error flags.
// Optional: define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling around mid-bit.
module uart_rx_oversampled #(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16,
    parameter int CLK_DIV     = 326
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int MID   = OVERSAMPLE / 2 - 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int EVAL_CNT = MID + 1;
`else
    localparam int EVAL_CNT = MID;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t r_state, w_next_state;

    logic                 r_sync1, r_sync2, r_line_prev;
    logic [DIV_W-1:0]     r_div_cnt;
    logic [OS_W-1:0]      r_os_cnt;
    logic [3:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_acc, r_par_err, r_frame_acc, r_any_high;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid, r_parity_err, r_frame_err, r_break_det, r_overrun;
    logic                 w_line, w_fall, w_tick, w_eval, w_bit;
    logic                 w_last_data, w_last_stop, w_frame_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_line_prev <= 1'b1;
        end else begin
            r_sync1     <= rx_in;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;
        end
    end

    assign w_line = r_sync2;
    assign w_fall = r_line_prev & ~r_sync2;
    assign w_tick = (r_div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_div_cnt <= '0;
        else if (w_tick) r_div_cnt <= '0;
        else             r_div_cnt <= r_div_cnt + 1'b1;
    end

`ifdef UART_RX_MAJORITY_EN
    // History of the two previous tick samples; the vote is taken on the mid+1 tick.
    logic [1:0] r_hist;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_hist <= 2'b11;
        else if (w_tick) r_hist <= {r_hist[0], w_line};
    end
    assign w_bit = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_line) | (r_hist[0] & w_line);
`else
    assign w_bit = w_line;
`endif

    assign w_eval = w_tick && (r_os_cnt == OS_W'(EVAL_CNT))
                    && (r_state != S_IDLE) && (r_state != S_WAIT_IDLE);
    assign w_last_data  = (r_bit_cnt == 4'(DATA_BITS - 1));
    assign w_last_stop  = (r_bit_cnt == 4'(STOP_BITS - 1));
    assign w_frame_done = w_eval && (r_state == S_STOP) && w_last_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (w_fall) w_next_state = S_START;
            S_START:     if (w_eval) w_next_state = w_bit ? S_IDLE : S_DATA;
            S_DATA:      if (w_eval && w_last_data)
                             w_next_state = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (w_eval) w_next_state = S_STOP;
            S_STOP:      if (w_eval && w_last_stop)
                             w_next_state = w_bit ? S_IDLE : S_WAIT_IDLE;
            S_WAIT_IDLE: if (w_line) w_next_state = S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    // The oversample counter is held at zero in IDLE so START begins counting from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt    <= '0;
            r_bit_cnt   <= 4'd0;
            r_shift     <= '0;
            r_par_acc   <= 1'b0;
            r_par_err   <= 1'b0;
            r_frame_acc <= 1'b0;
            r_any_high  <= 1'b0;
        end else begin
            if (r_state == S_IDLE) r_os_cnt <= '0;
            else if (w_tick)       r_os_cnt <= r_os_cnt + 1'b1;
            if (w_eval) begin
                case (r_state)
                    S_START: begin
                        r_bit_cnt   <= 4'd0;
                        r_par_acc   <= 1'b0;
                        r_par_err   <= 1'b0;
                        r_frame_acc <= 1'b0;
                        r_any_high  <= 1'b0;
                    end
                    S_DATA: begin
                        r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
                        r_par_acc  <= r_par_acc ^ w_bit;
                        r_any_high <= r_any_high | w_bit;
                        r_bit_cnt  <= w_last_data ? 4'd0 : r_bit_cnt + 4'd1;
                    end
                    S_PARITY: begin
                        r_par_err  <= (PARITY_MODE == 1) ? (r_par_acc ^ w_bit) : ~(r_par_acc ^ w_bit);
                        r_any_high <= r_any_high | w_bit;
                        r_bit_cnt  <= 4'd0;
                    end
                    S_STOP: begin
                        r_frame_acc <= r_frame_acc | ~w_bit;
                        r_any_high  <= r_any_high | w_bit;
                        r_bit_cnt   <= w_last_stop ? 4'd0 : r_bit_cnt + 4'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // A completing frame wins over a same-cycle handshake; it is dropped only if the word is still held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_break_det  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_frame_done) begin
                if (r_rx_valid && !rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_rx_data    <= r_shift;
                    r_rx_valid   <= 1'b1;
                    r_parity_err <= r_par_err;
                    r_frame_err  <= r_frame_acc | ~w_bit;
                    r_break_det  <= ~(r_any_high | w_bit);
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign parity_err  = r_parity_err;
    assign frame_err   = r_frame_err;
    assign break_det   = r_break_det;
    assign overrun_err = r_overrun;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb/tb_uart_rx_oversampled.sv - Self-checking bench: 8N1 and 8E1 receivers against a frame-level model.
module tb_uart_rx_oversampled;
    localparam int BIT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line_a = 1'b1, line_b = 1'b1;
    logic       rdy_a = 1'b1, rdy_b = 1'b1;
    logic [7:0] data_a, data_b;
    logic       valid_a, pe_a, fe_a, bd_a, ovr_a, busy_a;
    logic       valid_b, pe_b, fe_b, bd_b, ovr_b, busy_b;

    int checks = 0;
    int errors = 0;
    int vcnt_a = 0;
    int ocnt_a = 0;
    logic [10:0] q_a[$];
    logic [10:0] q_b[$];

    uart_rx_oversampled #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                          .OVERSAMPLE(16), .CLK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .rx_in(line_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a),
        .overrun_err(ovr_a), .busy(busy_a));

    uart_rx_oversampled #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
                          .OVERSAMPLE(16), .CLK_DIV(4)) dut_b (
        .clk(clk), .rst(rst), .rx_in(line_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .break_det(bd_b),
        .overrun_err(ovr_b), .busy(busy_b));

    always #5 clk = ~clk;

    // Words are recorded on the handshake; entries are {break, frame, parity, data}.
    always @(negedge clk) begin
        if (valid_a) vcnt_a++;
        if (ovr_a) ocnt_a++;
        if (valid_a && rdy_a) q_a.push_back({bd_a, fe_a, pe_a, data_a});
        if (valid_b && rdy_b) q_b.push_back({bd_b, fe_b, pe_b, data_b});
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        if (which == 0) line_a = v;
        else            line_b = v;
    endtask

    // which=1 targets the even-parity receiver and inserts parity bit p.
    task automatic send_frame(input int which, input logic [7:0] d, input logic p, input logic stop);
        set_line(which, 1'b0);
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            wait_clks(BIT);
        end
        if (which == 1) begin
            set_line(which, p);
            wait_clks(BIT);
        end
        set_line(which, stop);
        wait_clks(BIT);
        set_line(which, 1'b1);
        wait_clks(BIT);
    endtask

    task automatic send_glitch_a(input logic [7:0] d, input int gbit, input int off, input int len);
        line_a = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 8; i++) begin
            line_a = d[i];
            if (i == gbit) begin
                wait_clks(off);
                line_a = ~d[i];
                wait_clks(len);
                line_a = d[i];
                wait_clks(BIT - off - len);
            end else begin
                wait_clks(BIT);
            end
        end
        line_a = 1'b1;
        wait_clks(2 * BIT);
    endtask

    function automatic logic [10:0] model(input int which, input logic [7:0] d, input logic p, input logic stop);
        logic pe, fe, bd;
        pe = (which == 1) ? ^{d, p} : 1'b0;
        fe = ~stop;
        bd = (d == 8'h00) && !stop && ((which == 0) || !p);
        return {bd, fe, pe, d};
    endfunction

    task automatic test_reset();
        wait_clks(3);
        checks++;
        if ({valid_a, pe_a, fe_a, bd_a, ovr_a, busy_a, data_a} !== 14'd0) begin
            errors++;
            $display("FAIL reset_a got %h exp 0", {valid_a, pe_a, fe_a, bd_a, ovr_a, busy_a, data_a});
        end
        checks++;
        if ({valid_b, pe_b, fe_b, bd_b, ovr_b, busy_b, data_b} !== 14'd0) begin
            errors++;
            $display("FAIL reset_b got %h exp 0", {valid_b, pe_b, fe_b, bd_b, ovr_b, busy_b, data_b});
        end
        rst = 1'b0;
        wait_clks(20);
        checks++;
        if ({valid_a, busy_a, valid_b, busy_b} !== 4'd0) begin
            errors++;
            $display("FAIL post_reset_idle got %b exp 0000", {valid_a, busy_a, valid_b, busy_b});
        end
    endtask

    task automatic test_basic();
        q_a.delete();
        vcnt_a = 0;
        rdy_a = 1'b1;
        send_frame(0, 8'hA5, 1'b0, 1'b1);
        checks++;
        if (q_a.size() != 1 || q_a[0] !== {3'b000, 8'hA5}) begin
            errors++;
            $display("FAIL basic_a5 got %h n=%0d exp %h", (q_a.size() > 0) ? q_a[0] : 11'h0, q_a.size(), {3'b000, 8'hA5});
        end
        checks++;
        if (vcnt_a != 1) begin
            errors++;
            $display("FAIL basic_valid_cycles got %0d exp 1", vcnt_a);
        end
    endtask

    task automatic test_random();
        logic [7:0]  d;
        logic        p, s;
        logic [10:0] exp_w;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            int which;
            which = i % 2;
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            if ((i % 5) == 4) d = 8'h00;
            exp_w = model(which, d, p, s);
            q_a.delete();
            q_b.delete();
            send_frame(which, d, p, s);
            checks++;
            if (which == 0) begin
                if (q_a.size() != 1 || q_a[0] !== exp_w) begin
                    errors++;
                    $display("FAIL random_a[%0d] got %h n=%0d exp %h", i, (q_a.size() > 0) ? q_a[0] : 11'h0, q_a.size(), exp_w);
                end
            end else begin
                if (q_b.size() != 1 || q_b[0] !== exp_w) begin
                    errors++;
                    $display("FAIL random_b[%0d] got %h n=%0d exp %h", i, (q_b.size() > 0) ? q_b[0] : 11'h0, q_b.size(), exp_w);
                end
            end
        end
    endtask

    task automatic test_parity();
        q_b.delete();
        rdy_b = 1'b1;
        send_frame(1, 8'h07, 1'b0, 1'b1);
        checks++;
        if (q_b.size() != 1 || q_b[0] !== {3'b001, 8'h07}) begin
            errors++;
            $display("FAIL parity_bad got %h n=%0d exp %h", (q_b.size() > 0) ? q_b[0] : 11'h0, q_b.size(), {3'b001, 8'h07});
        end
        q_b.delete();
        send_frame(1, 8'h07, 1'b1, 1'b1);
        checks++;
        if (q_b.size() != 1 || q_b[0] !== {3'b000, 8'h07}) begin
            errors++;
            $display("FAIL parity_good got %h n=%0d exp %h", (q_b.size() > 0) ? q_b[0] : 11'h0, q_b.size(), {3'b000, 8'h07});
        end
    endtask

    task automatic test_overrun();
        q_a.delete();
        ocnt_a = 0;
        rdy_a = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1);
        send_frame(0, 8'h22, 1'b0, 1'b1);
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'h11) begin
            errors++;
            $display("FAIL overrun_hold got valid=%b data=%h exp valid=1 data=11", valid_a, data_a);
        end
        checks++;
        if (ocnt_a != 1) begin
            errors++;
            $display("FAIL overrun_pulses got %0d exp 1", ocnt_a);
        end
        rdy_a = 1'b1;
        wait_clks(2);
        checks++;
        if (q_a.size() != 1 || q_a[0] !== {3'b000, 8'h11}) begin
            errors++;
            $display("FAIL overrun_accept got %h n=%0d exp %h", (q_a.size() > 0) ? q_a[0] : 11'h0, q_a.size(), {3'b000, 8'h11});
        end
        wait_clks(3 * BIT);
        checks++;
        if (q_a.size() != 1 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL overrun_dropped got n=%0d valid=%b exp n=1 valid=0", q_a.size(), valid_a);
        end
    endtask

    task automatic test_break();
        q_a.delete();
        rdy_a = 1'b1;
        line_a = 1'b0;
        wait_clks(12 * BIT - 10);
        checks++;
        if (busy_a !== 1'b1 || q_a.size() != 1) begin
            errors++;
            $display("FAIL break_held got busy=%b n=%0d exp busy=1 n=1", busy_a, q_a.size());
        end
        line_a = 1'b1;
        wait_clks(8);
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL break_release_busy got %b exp 0", busy_a);
        end
        wait_clks(2 * BIT);
        checks++;
        if (q_a.size() != 1 || q_a[0] !== {3'b110, 8'h00}) begin
            errors++;
            $display("FAIL break_word got %h n=%0d exp %h", (q_a.size() > 0) ? q_a[0] : 11'h0, q_a.size(), {3'b110, 8'h00});
        end
    endtask

    task automatic test_glitch();
        q_a.delete();
        rdy_a = 1'b1;
        line_a = 1'b0;
        wait_clks(10);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL glitch_start_busy got %b exp 1", busy_a);
        end
        wait_clks(10);
        line_a = 1'b1;
        wait_clks(2 * BIT);
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || q_a.size() != 0) begin
            errors++;
            $display("FAIL false_start got busy=%b valid=%b n=%0d exp 0 0 0", busy_a, valid_a, q_a.size());
        end
`ifdef UART_RX_MAJORITY_EN
        send_glitch_a(8'h3C, 2, 32, 3);
`else
        send_glitch_a(8'h3C, 2, 4, 3);
`endif
        checks++;
        if (q_a.size() != 1 || q_a[0] !== {3'b000, 8'h3C}) begin
            errors++;
            $display("FAIL glitch_3c got %h n=%0d exp %h", (q_a.size() > 0) ? q_a[0] : 11'h0, q_a.size(), {3'b000, 8'h3C});
        end
    endtask

    task automatic test_reset_midframe();
        q_a.delete();
        rdy_a = 1'b1;
        line_a = 1'b0;
        wait_clks(BIT);
        for (int i = 0; i < 4; i++) begin
            line_a = 1'b1;
            wait_clks(BIT);
        end
        wait_clks(20);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy got %b exp 1", busy_a);
        end
        rst = 1'b1;
        wait_clks(3);
        checks++;
        if ({valid_a, pe_a, fe_a, bd_a, ovr_a, busy_a, data_a} !== 14'd0) begin
            errors++;
            $display("FAIL midframe_reset got %h exp 0", {valid_a, pe_a, fe_a, bd_a, ovr_a, busy_a, data_a});
        end
        rst = 1'b0;
        wait_clks(2 * BIT);
        checks++;
        if (q_a.size() != 0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midframe_discard got n=%0d busy=%b exp 0 0", q_a.size(), busy_a);
        end
        send_frame(0, 8'h5A, 1'b0, 1'b1);
        checks++;
        if (q_a.size() != 1 || q_a[0] !== {3'b000, 8'h5A}) begin
            errors++;
            $display("FAIL midframe_next got %h n=%0d exp %h", (q_a.size() > 0) ? q_a[0] : 11'h0, q_a.size(), {3'b000, 8'h5A});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_parity();
        test_overrun();
        test_break();
        test_glitch();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_oversampled.md
UART_RX_OVERSAMPLED -- requirements
Module: uart_rx_oversampled

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal 5..9.
REQ-002 SHALL have parameter PARITY_MODE, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-004 SHALL have parameter OVERSAMPLE, default 16, oversample ticks per bit, legal 8 or 16.
REQ-005 SHALL have parameter CLK_DIV, default 326, clk cycles per oversample tick, minimum 2.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port rx_in, input, 1, asynchronous serial line, idle high.
REQ-009 SHALL have port rx_data, output, DATA_BITS, received word, LSB is first bit received.
REQ-010 SHALL have port rx_valid, output, 1, rx_data and error flags valid.
REQ-011 SHALL have port rx_ready, input, 1, consumer accepts the word.
REQ-012 SHALL have port parity_err, output, 1, parity mismatch for the held word.
REQ-013 SHALL have port frame_err, output, 1, a stop bit sampled low for the held word.
REQ-014 SHALL have port break_det, output, 1, held word was a break: all data, parity and stop samples low.
REQ-015 SHALL have port overrun_err, output, 1, one-cycle pulse when a frame is dropped.
REQ-016 SHALL have port busy, output, 1, high in every FSM state except IDLE.

Function
REQ-017 SHALL synchronise rx_in through two flops reset to 1; all logic uses the synchronised value.
REQ-018 SHALL generate a one-cycle tick every CLK_DIV clk cycles; the tick counter runs freely from reset.
REQ-019 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE.
REQ-020 SHALL leave IDLE for START on a 1->0 transition of the synchronised line and clear the oversample counter.
REQ-021 SHALL sample START at oversample count OVERSAMPLE/2-1; a high sample returns to IDLE with no flags (false start).
REQ-022 SHALL take each later sample exactly OVERSAMPLE ticks after the previous one (mid-bit).
REQ-023 SHALL collect DATA_BITS samples LSB first, then go to PARITY if PARITY_MODE!=0, else to STOP.
REQ-024 SHALL set the parity error when the XOR of data and parity samples is 1 (even) or 0 (odd).
REQ-025 SHALL sample STOP_BITS stop bits; any low stop sample sets the frame error.
REQ-026 SHALL, after the last stop sample, go to IDLE if that sample was high, else to WAIT_IDLE.
REQ-027 SHALL stay in WAIT_IDLE until the synchronised line is high, then go to IDLE, so a held-low line yields one frame.
REQ-028 SHALL load rx_data and the flags and assert rx_valid on the clk cycle after the tick of the last stop sample.
REQ-029 SHALL hold rx_valid, rx_data and the flags stable until a cycle where rx_valid and rx_ready are both high; rx_valid then drops next cycle.
REQ-030 SHALL, if a frame completes while rx_valid is high and rx_ready is low, keep the held word, discard the new one and pulse overrun_err.
REQ-031 SHALL, if a frame completes in the same cycle as a handshake, load the new frame and keep rx_valid high with no overrun.

Reset
REQ-032 SHALL on rst force the FSM to IDLE and clear all counters.
REQ-033 SHALL on rst clear rx_data, rx_valid, parity_err, frame_err, break_det, overrun_err and busy to 0.
REQ-034 SHALL on rst set the synchroniser flops to 1.
REQ-035 SHALL on rst mid-frame discard the partial frame; the next frame is received normally.

Configuration
REQ-036 SHALL, with UART_RX_MAJORITY_EN defined, take each bit as the 2-of-3 majority of oversample counts mid-1, mid and mid+1.
REQ-037 SHALL, without UART_RX_MAJORITY_EN, take each bit as the single sample at count mid; the rest of the timing is identical.

Verification (CLK_DIV=4, OVERSAMPLE=16, 64 clk/bit)
REQ-038 SHALL test: 8N1 frame 0xA5, rx_ready=1 -> rx_valid for 1 cycle, rx_data=0xA5, all flags 0.
REQ-039 SHALL test: PARITY_MODE=1, 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1; same data with parity bit 1 -> parity_err=0.
REQ-040 SHALL test: rx_ready=0, frames 0x11 then 0x22 -> rx_data stays 0x11, one overrun_err pulse; after the handshake 0x22 is never presented.
REQ-041 SHALL test: line low for 12 bit times then high -> one word 0x00 with frame_err=1 and break_det=1, busy until the line rises, no second frame.
REQ-042 SHALL test: 20-clk low glitch -> false start, back to IDLE, rx_valid stays 0; with the macro, a 1-tick mid-bit glitch inside 0x3C -> rx_data still 0x3C.
REQ-043 SHALL test: rst asserted during data bit 4 of 0xFF, then a clean 0x5A -> all outputs 0 during reset, then rx_data=0x5A with flags 0.
